// File: rtl/posit_defines.sv
// Shared widths, serialized value layouts and the round-to-nearest-even helper
// for the ES2 product-to-sum conversion path.
package posit_defines;

    localparam int SBITS = 8;
    localparam int ABITS = 31;
    localparam int MBITS = 56;

    localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES2 = 1 + SBITS + MBITS + 2;
    localparam int POSIT_SERIALIZED_WIDTH_SUM_ES2     = 1 + SBITS + ABITS + 2;

    // Product fraction bits below the kept field feed guard and sticky.
    localparam int KEEP_LSB  = MBITS - ABITS;
    localparam int GUARD_BIT = KEEP_LSB - 1;

    localparam logic signed [SBITS-1:0] SCALE_MAX = 8'sd127;

    typedef struct packed {
        logic                    sgn;
        logic signed [SBITS-1:0] scale;
        logic [MBITS-1:0]        fraction;
        logic                    inf;
        logic                    zero;
    } value_product;

    typedef struct packed {
        logic                    sgn;
        logic signed [SBITS-1:0] scale;
        logic [ABITS-1:0]        fraction;
        logic                    inf;
        logic                    zero;
    } value_sum;

    typedef struct packed {
        logic                    sgn;
        logic signed [SBITS-1:0] scale;
        logic [ABITS-1:0]        keep;
        logic                    guard;
        logic                    sticky;
        logic                    inf;
        logic                    zero;
        logic                    in_trunc;
    } stage1_t;

    typedef struct packed {
        value_sum value;
        logic     truncated;
    } sum_entry_t;

    localparam int SUM_ENTRY_W = $bits(sum_entry_t);

    // Round-to-nearest-even of the kept field, with carry into scale and
    // saturation at the top of the scale range.
    function automatic sum_entry_t round_to_sum(input stage1_t s);
        sum_entry_t       r;
        logic             round_up;
        logic [ABITS:0]   inc;
        r        = '0;
        round_up = s.guard & (s.sticky | s.keep[0]);
        inc      = {1'b0, s.keep} + {{ABITS{1'b0}}, round_up};
        if (s.inf) begin
            r.value.inf = 1'b1;
        end else if (s.zero) begin
            r.value.zero = 1'b1;
        end else begin
            r.value.sgn = s.sgn;
            r.truncated = s.in_trunc | s.guard | s.sticky;
            if (inc[ABITS]) begin
                if (s.scale == SCALE_MAX) begin
                    r.value.scale    = SCALE_MAX;
                    r.value.fraction = '1;
                    r.truncated      = 1'b1;
                end else begin
                    r.value.scale    = s.scale + 8'sd1;
                    r.value.fraction = '0;
                end
            end else begin
                r.value.scale    = s.scale;
                r.value.fraction = inc[ABITS-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/positprod_to_sumval_es2_fifo.sv
// Synchronous output FIFO with occupancy count; the producer uses the count
// as a credit so a push never lands on a full buffer without a pop.
module sync_fifo_credit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             pop_ok;

    assign empty    = (count_q == '0);
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/positprod_to_sumval_es2.sv
// Converts a raw ES2 posit product into a rounded sum-width value through a
// two-stage pipeline feeding a credit-managed output FIFO.
module positprod_to_sumval_es2
    import posit_defines::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES2-1:0] in,
    input  logic                                          in_truncated,
    input  logic                                          start,
    output logic                                          in_ready,
    output logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]     result,
    output logic                                          truncated,
    output logic                                          done,
    input  logic                                          out_ready,
    output logic                                          overrun
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    value_product in_val;
    logic         start_clean;
    logic         accept;

    logic         s1_valid_q, s1_valid_d;
    stage1_t      s1_q,       s1_d;
    logic         s2_valid_q, s2_valid_d;
    sum_entry_t   s2_q,       s2_d;
    logic         overrun_q,  overrun_d;

    sum_entry_t   head;
    logic         fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;

    assign in_val      = value_product'(in);
    // An X or Z on start must not launch a transaction.
    assign start_clean = (start === 1'b1);

    always_comb begin
        credit_used = {1'b0, fifo_count}
                    + {{CNT_W{1'b0}}, s1_valid_q}
                    + {{CNT_W{1'b0}}, s2_valid_q};
        in_ready    = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        accept      = start_clean & in_ready;
    end

    always_comb begin
        s1_valid_d     = accept;
        s1_d.sgn       = in_val.sgn;
        s1_d.scale     = in_val.scale;
        s1_d.keep      = in_val.fraction[MBITS-1:KEEP_LSB];
        s1_d.guard     = in_val.fraction[GUARD_BIT];
        s1_d.sticky    = |in_val.fraction[GUARD_BIT-1:0];
        s1_d.inf       = in_val.inf;
        s1_d.zero      = in_val.zero;
        s1_d.in_trunc  = in_truncated;

        s2_valid_d     = s1_valid_q;
        s2_d           = round_to_sum(s1_q);

        overrun_d      = overrun_q | (start_clean & ~in_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Payload registers are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    sync_fifo_credit #(
        .WIDTH (SUM_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_valid_q),
        .push_data (s2_q),
        .pop       (done & out_ready),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Masking the head keeps outputs at zero while nothing valid is buffered.
    always_comb begin
        done      = ~fifo_empty;
        result    = done ? head.value : '0;
        truncated = done & head.truncated;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_positprod_to_sumval_es2.sv
// Directed bench: hand-computed rounding vectors, latency, backpressure with
// credit/overrun behaviour, X on start, and reset while transactions are in flight.
module tb_positprod_to_sumval_es2;
    import posit_defines::*;

    localparam int PW = POSIT_SERIALIZED_WIDTH_PRODUCT_ES2;
    localparam int SW = POSIT_SERIALIZED_WIDTH_SUM_ES2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] in_bus;
    logic          in_trunc;
    logic          start;
    logic          in_ready;
    logic [SW-1:0] result;
    logic          truncated;
    logic          done;
    logic          out_ready;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    positprod_to_sumval_es2 #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in           (in_bus),
        .in_truncated (in_trunc),
        .start        (start),
        .in_ready     (in_ready),
        .result       (result),
        .truncated    (truncated),
        .done         (done),
        .out_ready    (out_ready),
        .overrun      (overrun)
    );

    function automatic logic [PW-1:0] mk_prod(input logic sgn, input logic [7:0] sc,
                                              input logic [55:0] fr, input logic inf,
                                              input logic zero);
        return {sgn, sc, fr, inf, zero};
    endfunction

    function automatic logic [SW-1:0] mk_sum(input logic sgn, input logic [7:0] sc,
                                             input logic [30:0] fr, input logic inf,
                                             input logic zero);
        return {sgn, sc, fr, inf, zero};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction: done must be low two cycles after start and high on the third.
    task automatic run_one(input string tag, input logic [PW-1:0] p, input logic tr,
                           input logic [SW-1:0] exp_r, input logic exp_t);
        in_bus   = p;
        in_trunc = tr;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_bus   = '0;
        in_trunc = 1'b0;
        @(negedge clk);
        check({tag, "_done_c2"}, 64'(done), 64'(1'b0));
        @(negedge clk);
        check({tag, "_done_c3"}, 64'(done), 64'(1'b1));
        check({tag, "_result"}, 64'(result), 64'(exp_r));
        check({tag, "_trunc"}, 64'(truncated), 64'(exp_t));
        @(negedge clk);
        check({tag, "_popped"}, 64'(done), 64'(1'b0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_bus    = '0;
        in_trunc  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_result", 64'(result), 64'(0));
        check("rst_trunc", 64'(truncated), 64'(1'b0));
        check("rst_overrun", 64'(overrun), 64'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_one("exact_s3", mk_prod(1'b0, 8'd3, 56'h80_0000_0000_0000, 1'b0, 1'b0), 1'b0,
                mk_sum(1'b0, 8'd3, 31'h4000_0000, 1'b0, 1'b0), 1'b0);
        run_one("carry_s5", mk_prod(1'b0, 8'd5, 56'hFF_FFFF_FF00_0000, 1'b0, 1'b0), 1'b0,
                mk_sum(1'b0, 8'd6, 31'h0, 1'b0, 1'b0), 1'b1);
        run_one("tie_even", mk_prod(1'b1, 8'hFE, 56'h00_0000_0500_0000, 1'b0, 1'b0), 1'b0,
                mk_sum(1'b1, 8'hFE, 31'h2, 1'b0, 1'b0), 1'b1);
        run_one("tie_odd", mk_prod(1'b1, 8'hFE, 56'h00_0000_0700_0000, 1'b0, 1'b0), 1'b0,
                mk_sum(1'b1, 8'hFE, 31'h4, 1'b0, 1'b0), 1'b1);
        run_one("sat_127", mk_prod(1'b0, 8'd127, 56'hFF_FFFF_FF00_0000, 1'b0, 1'b0), 1'b0,
                mk_sum(1'b0, 8'd127, 31'h7FFF_FFFF, 1'b0, 1'b0), 1'b1);
        run_one("sticky_only", mk_prod(1'b0, 8'h80, 56'h00_0000_0000_0001, 1'b0, 1'b0), 1'b0,
                mk_sum(1'b0, 8'h80, 31'h0, 1'b0, 1'b0), 1'b1);
        run_one("in_trunc", mk_prod(1'b1, 8'd0, 56'h0, 1'b0, 1'b0), 1'b1,
                mk_sum(1'b1, 8'd0, 31'h0, 1'b0, 1'b0), 1'b1);
        run_one("zero_in", mk_prod(1'b1, 8'd9, 56'hFF_FFFF_FFFF_FFFF, 1'b0, 1'b1), 1'b1,
                mk_sum(1'b0, 8'd0, 31'h0, 1'b0, 1'b1), 1'b0);

        // X on start must launch nothing.
        start = 1'bx;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("xstart_done", 64'(done), 64'(1'b0));
        check("xstart_overrun", 64'(overrun), 64'(1'b0));

        // Backpressure: six back-to-back starts, only four fit the credit.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'(i < 4));
            in_bus = mk_prod(1'b0, 8'(i), 56'h0, 1'b0, 1'b0);
            start  = 1'b1;
            @(negedge clk);
        end
        start  = 1'b0;
        in_bus = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp_overrun", 64'(overrun), 64'(1'b1));
        check("bp_full_in_ready", 64'(in_ready), 64'(1'b0));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_done_%0d", i), 64'(done), 64'(1'b1));
            check($sformatf("bp_result_%0d", i), 64'(result),
                  64'(mk_sum(1'b0, 8'(i), 31'h0, 1'b0, 1'b0)));
            out_ready = 1'b1;
            @(negedge clk);
        end
        check("bp_drained", 64'(done), 64'(1'b0));
        check("bp_in_ready_back", 64'(in_ready), 64'(1'b1));
        check("bp_overrun_sticky", 64'(overrun), 64'(1'b1));

        run_one("inf_zero", mk_prod(1'b1, 8'd7, 56'h12_3456_789A_BCDE, 1'b1, 1'b1), 1'b1,
                mk_sum(1'b0, 8'd0, 31'h0, 1'b1, 1'b0), 1'b0);

        // Reset with two transactions in flight discards both.
        in_bus = mk_prod(1'b0, 8'd1, 56'h0, 1'b1, 1'b0);
        start  = 1'b1;
        @(negedge clk);
        in_bus = mk_prod(1'b0, 8'd2, 56'h0, 1'b0, 1'b0);
        @(negedge clk);
        start  = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_done", 64'(done), 64'(1'b0));
        check("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_trunc", 64'(truncated), 64'(1'b0));
        check("midrst_overrun", 64'(overrun), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("postrst_done_%0d", i), 64'(done), 64'(1'b0));
        end
        check("postrst_overrun", 64'(overrun), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/positprod_to_sumval_es2.md
POSITPROD_TO_SUMVAL_ES2 -- requirements
Module: positprod_to_sumval_es2

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, >= 2.
REQ-002 Port list: clk  in  1  single clock, all state on rising edge.
REQ-003 Port list: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port list: in  in  POSIT_SERIALIZED_WIDTH_PRODUCT_ES2  raw product {sgn, scale[7:0], fraction[MBITS-1:0], inf, zero}.
REQ-005 Port list: in_truncated  in  1  upstream inexact flag.
REQ-006 Port list: start  in  1  input valid for one cycle.
REQ-007 Port list: in_ready  out  1  block can accept start this cycle.
REQ-008 Port list: result  out  POSIT_SERIALIZED_WIDTH_SUM_ES2  sum value {sgn, scale[7:0], fraction[ABITS-1:0], inf, zero}.
REQ-009 Port list: truncated  out  1  result inexact.
REQ-010 Port list: done  out  1  result valid (FIFO not empty).
REQ-011 Port list: out_ready  in  1  downstream accepts; pop when done & out_ready.
REQ-012 Port list: overrun  out  1  sticky: a start was dropped.

Function
REQ-013 Scale is 8-bit two's complement; product fraction MBITS=56 bits with hidden bit removed; sum fraction ABITS=31 bits.
REQ-014 Two-stage pipeline then FIFO: start to earliest done = 3 cycles (stage1 reg, stage2 reg, FIFO write, head visible next cycle).
REQ-015 Stage 1 registers fields; computes keep=fraction[55:25], guard=fraction[24], sticky=|fraction[23:0].
REQ-016 Rounding is round-to-nearest-even: increment keep iff guard & (sticky | keep[0]).
REQ-017 Stage 2: increment carry-out from keep clears fraction to 0 and adds 1 to scale.
REQ-018 Scale 127 with rounding carry saturates: scale 127, fraction all ones, truncated 1.
REQ-019 truncated out = in_truncated | guard | sticky (or saturation).
REQ-020 zero=1 input: sgn, scale, fraction, inf all 0, zero 1, truncated 0, no rounding.
REQ-021 inf=1 input: sgn, scale, fraction, zero all 0, inf 1, truncated 0; inf dominates when both set.
REQ-022 in_ready = (fifo_count + valid stages in flight) < FIFO_DEPTH, combinational from registered state.
REQ-023 start with in_ready=0 is dropped and sets overrun; overrun clears only on reset.
REQ-024 start with X value is treated as 0.
REQ-025 Simultaneous push and pop on a full FIFO is legal; count unchanged.
REQ-026 Pointers wrap modulo FIFO_DEPTH; result/truncated are driven from FIFO head; don't-care when done=0.
REQ-027 Pipeline never stalls; in_ready credit guarantees no FIFO overflow.

Reset
REQ-028 rst_n low asynchronously clears stage valids, FIFO pointers/count, overrun; done=0, in_ready=1, result=0, truncated=0.
REQ-029 Reset mid-operation discards all in-flight and buffered results; no done after release until new start.
REQ-030 Data path registers need no reset; only valid/control state is reset.

Structure
REQ-031 SBITS=8, ABITS, MBITS, width constants and value_sum/value_product typedefs live in posit_defines.
REQ-032 One sub-module, sync_fifo_credit (parameterised width/depth, count output), holds the output buffer.

Verification
REQ-033 Fraction 0x80_0000_0000_0000 (guard bit 54 only above keep? no: fraction[55]=1, rest 0), scale 3 -> result fraction 0x4000_0000, scale 3, truncated 0, done at cycle 3.
REQ-034 fraction[55:25]=all ones, guard=1, scale 5 -> fraction 0, scale 6, truncated 1.
REQ-035 Exact tie: keep LSB 0, guard 1, sticky 0 -> no increment; keep LSB 1 -> increment; both truncated 1.
REQ-036 scale 127, keep all ones, guard 1 -> scale 127, fraction 0x7FFF_FFFF, truncated 1.
REQ-037 out_ready=0, 6 back-to-back starts -> 4 accepted, in_ready drops after 4th, 2 dropped, overrun 1; then out_ready=1 -> 4 results in order.
REQ-038 inf=1 & zero=1 input, then rst_n pulse with 2 in flight -> inf result only if before reset; after reset done=0, overrun=0.
